// File: rtl/pattern_det_pkg.sv
// Shared types and default sizing for the serial pattern detector.
package pattern_det_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int LEN_W_DEF = 10;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width needed to count 0..pat_w inclusive.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/pat_matcher.sv
// Serial history shift register, fill tracker and pattern comparator.
// hit reflects the bit being accepted this cycle (post-shift view).
module pat_matcher
  import pattern_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             accept,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             ovl_mode,
  output logic             hit
);

  localparam int                FILL_W    = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  history;
  logic [PAT_W-1:0]  history_nxt;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;

  always_comb begin
    history_nxt = {history[PAT_W-2:0], bit_in};
    fill_nxt    = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    hit         = accept && (fill_nxt == FILL_FULL) && (history_nxt == pattern);
  end

  // Non-overlapping mode restarts the window after every hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      history <= '0;
      fill    <= '0;
    end else if (clr) begin
      history <= '0;
      fill    <= '0;
    end else if (accept) begin
      history <= history_nxt;
      fill    <= (hit && !ovl_mode) ? '0 : fill_nxt;
    end
  end

endmodule

// File: rtl/pattern_det_ctrl.sv
// Frame controller for the serial pattern detector: IDLE/RUN/DONE FSM,
// frame bit counter and match counter. Define MATCH_CNT_SAT_EN to make
// match_cnt saturate instead of wrapping.
module pattern_det_ctrl
  import pattern_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic             ovl_mode,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic             busy,
  output logic             match,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  state_t           state;
  logic [PAT_W-1:0] pattern_q;
  logic             ovl_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_cnt;
  logic [LEN_W-1:0] bit_cnt_nxt;
  logic             clr;
  logic             accept;
  logic             last_bit;
  logic             hit;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
`ifdef MATCH_CNT_SAT_EN
    return (&c) ? c : c + CNT_W'(1);
`else
    return c + CNT_W'(1);
`endif
  endfunction

  // An abort in the same cycle discards the offered bit.
  always_comb begin
    clr         = (state == IDLE) && start;
    accept      = (state == RUN) && bit_valid && !abort;
    bit_cnt_nxt = bit_cnt + LEN_W'(1);
    last_bit    = accept && (bit_cnt_nxt == len_q);
  end

  pat_matcher #(
    .PAT_W (PAT_W)
  ) u_matcher (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .accept   (accept),
    .bit_in   (bit_in),
    .pattern  (pattern_q),
    .ovl_mode (ovl_q),
    .hit      (hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pattern_q <= '0;
      ovl_q     <= 1'b0;
      len_q     <= '0;
      bit_cnt   <= '0;
      match_cnt <= '0;
      match     <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      bit_ready <= 1'b0;
    end else begin
      match <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pattern_q <= pattern;
            ovl_q     <= ovl_mode;
            len_q     <= frame_len;
            bit_cnt   <= '0;
            match_cnt <= '0;
            busy      <= 1'b1;
            if (frame_len == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              bit_ready <= 1'b0;
            end else begin
              state     <= RUN;
              bit_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            bit_ready <= 1'b0;
          end else if (accept) begin
            bit_cnt <= bit_cnt_nxt;
            if (hit) begin
              match     <= 1'b1;
              match_cnt <= cnt_inc(match_cnt);
            end
            if (last_bit) begin
              state     <= DONE;
              done      <= 1'b1;
              bit_ready <= 1'b0;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          bit_ready <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          bit_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Randomized self-checking bench for pattern_det_ctrl with a window-based
// reference of pattern hits per frame.
module tb_pattern_det_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] pattern = '0;
  logic       ovl_mode = 1'b0;
  logic [9:0] frame_len = '0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_ready;
  logic       busy;
  logic       match;
  logic       done;
  logic [7:0] match_cnt;

  int checks = 0;
  int errors = 0;

  logic [3:0] f_pat;
  bit         f_ovl;
  int         f_len;
  bit         stim_bits[$];
  bit         exp_hit[$];
  int         obs_matches;
  int         obs_dones;
  bit         last_coincide;
  logic [7:0] model_cnt;

  pattern_det_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .pattern   (pattern),
    .ovl_mode  (ovl_mode),
    .frame_len (frame_len),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .bit_ready (bit_ready),
    .busy      (busy),
    .match     (match),
    .done      (done),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] cnt_step(input logic [7:0] c);
`ifdef MATCH_CNT_SAT_EN
    return (c == 8'hFF) ? c : c + 8'd1;
`else
    return c + 8'd1;
`endif
  endfunction

  // Sliding window of the bits seen since frame start or the last
  // non-overlapping hit; a hit is a full window equal to the pattern.
  function automatic void ref_hits();
    bit win[$];
    bit h;
    exp_hit.delete();
    for (int i = 0; i < stim_bits.size(); i++) begin
      win.push_back(stim_bits[i]);
      if (win.size() > 4) void'(win.pop_front());
      h = (win.size() == 4);
      for (int k = 0; k < 4; k++)
        if (h && win[k] != f_pat[3-k]) h = 0;
      exp_hit.push_back(h);
      if (h && !f_ovl) win.delete();
    end
  endfunction

  // Runs one frame; outputs are compared 1 time unit after each rising edge.
  // Vector order is {bit_ready, busy, match, done}.
  task automatic run_frame(input int valid_pct, input int abort_after);
    int         acc;
    int         cyc;
    bit         aborted;
    logic [3:0] got;
    logic [3:0] want;
    ref_hits();
    obs_matches = 0; obs_dones = 0; last_coincide = 0; model_cnt = '0;
    acc = 0; cyc = 0; aborted = 0;
    pattern = f_pat; ovl_mode = f_ovl; frame_len = 10'(f_len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    want = (f_len == 0) ? 4'b0101 : 4'b1100;
    got  = {bit_ready, busy, match, done};
    if (done) obs_dones++;
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL start_flags: got %b expected %b (len=%0d)", got, want, f_len);
    end
    checks++;
    if (match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL start_cnt: got %0d expected 0", match_cnt);
    end
    while (f_len > 0 && acc < f_len && !aborted && cyc < 60 * f_len + 100) begin
      bit_valid = (int'($urandom_range(99)) < valid_pct);
      bit_in    = stim_bits[acc];
      start     = 1'($urandom_range(1));
      pattern   = 4'($urandom);
      ovl_mode  = 1'($urandom);
      frame_len = 10'($urandom);
      abort     = (acc == abort_after);
      if (abort) bit_valid = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (abort) begin
        aborted = 1;
        want = 4'b0000;
      end else if (bit_valid) begin
        if (exp_hit[acc]) model_cnt = cnt_step(model_cnt);
        want = {(acc + 1 != f_len), 1'b1, exp_hit[acc], (acc + 1 == f_len)};
        acc++;
      end else begin
        want = 4'b1100;
      end
      got = {bit_ready, busy, match, done};
      if (match) obs_matches++;
      if (done) obs_dones++;
      if (match && done) last_coincide = 1;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL run_flags: got %b expected %b (bit %0d of %0d)", got, want, acc, f_len);
      end
      checks++;
      if (match_cnt !== model_cnt) begin
        errors++;
        $display("FAIL run_cnt: got %0d expected %0d (bit %0d)", match_cnt, model_cnt, acc);
      end
    end
    if (f_len > 0 && acc < f_len && !aborted) begin
      errors++;
      $display("FAIL frame_timeout: accepted %0d expected %0d", acc, f_len);
    end
    abort = 1'b0;
    bit_valid = 1'b1;
    start = !aborted;
    frame_len = 10'd5;
    @(posedge clk); #1;
    start = 1'b0;
    bit_valid = 1'b0;
    got = {bit_ready, busy, match, done};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL post_flags: got %b expected 0000", got);
    end
    @(posedge clk); #1;
    checks++;
    if ({bit_ready, busy, match, done} !== 4'b0000 || match_cnt !== model_cnt) begin
      errors++;
      $display("FAIL idle_hold: flags %b cnt %0d expected 0000 cnt %0d",
               {bit_ready, busy, match, done}, match_cnt, model_cnt);
    end
  endtask

  task automatic load_bits(input logic [31:0] bits, input int n);
    stim_bits.delete();
    for (int i = n - 1; i >= 0; i--) stim_bits.push_back(bits[i]);
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if ({bit_ready, busy, match, done} !== 4'b0000 || match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: flags %b cnt %0d expected 0000 cnt 0",
               {bit_ready, busy, match, done}, match_cnt);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_overlap();
    f_pat = 4'b1010; f_ovl = 1; f_len = 6;
    load_bits(32'b101010, 6);
    run_frame(100, -1);
    checks++;
    if (obs_matches != 2 || match_cnt !== 8'd2) begin
      errors++;
      $display("FAIL overlap: pulses %0d cnt %0d expected 2 and 2", obs_matches, match_cnt);
    end
  endtask

  task automatic test_non_overlap();
    f_pat = 4'b1010; f_ovl = 0; f_len = 6;
    load_bits(32'b101010, 6);
    run_frame(100, -1);
    checks++;
    if (obs_matches != 1 || match_cnt !== 8'd1) begin
      errors++;
      $display("FAIL non_overlap: pulses %0d cnt %0d expected 1 and 1", obs_matches, match_cnt);
    end
  endtask

  task automatic test_counter_limit();
    f_pat = 4'b0000; f_ovl = 1; f_len = 300;
    stim_bits.delete();
    for (int i = 0; i < 300; i++) stim_bits.push_back(1'b0);
    run_frame(100, -1);
    checks++;
`ifdef MATCH_CNT_SAT_EN
    if (obs_matches != 297 || match_cnt !== 8'd255) begin
      errors++;
      $display("FAIL counter_limit: pulses %0d cnt %0d expected 297 and 255", obs_matches, match_cnt);
    end
`else
    if (obs_matches != 297 || match_cnt !== 8'd41) begin
      errors++;
      $display("FAIL counter_limit: pulses %0d cnt %0d expected 297 and 41", obs_matches, match_cnt);
    end
`endif
  endtask

  task automatic test_zero_len();
    f_pat = 4'($urandom); f_ovl = 1; f_len = 0;
    stim_bits.delete();
    run_frame(100, -1);
    checks++;
    if (obs_dones != 1 || match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL zero_len: dones %0d cnt %0d expected 1 and 0", obs_dones, match_cnt);
    end
  endtask

  task automatic test_abort();
    f_pat = 4'b1111; f_ovl = 1; f_len = 8;
    load_bits(32'b11111111, 8);
    run_frame(100, 3);
    checks++;
    if (obs_dones != 0 || match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL abort: dones %0d cnt %0d expected 0 and 0", obs_dones, match_cnt);
    end
    f_pat = 4'b1010; f_ovl = 1; f_len = 4;
    load_bits(32'b1010, 4);
    run_frame(100, -1);
    checks++;
    if (match_cnt !== 8'd1 || !last_coincide) begin
      errors++;
      $display("FAIL after_abort: cnt %0d coincide %0d expected 1 and 1", match_cnt, last_coincide);
    end
  endtask

  task automatic test_reset_mid_frame();
    pattern = 4'b1111; ovl_mode = 1'b1; frame_len = 10'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bit_valid = 1'($urandom_range(1)) | (i < 5);
      bit_in = 1'b1;
      @(posedge clk); #1;
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({bit_ready, busy, match, done} !== 4'b0000 || match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: flags %b cnt %0d expected 0000 cnt 0",
               {bit_ready, busy, match, done}, match_cnt);
    end
    bit_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    test_overlap();
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      f_pat = 4'($urandom);
      f_ovl = 1'($urandom);
      f_len = int'($urandom_range(40, 1));
      stim_bits.delete();
      for (int i = 0; i < f_len; i++) stim_bits.push_back(1'($urandom));
      run_frame(int'($urandom_range(100, 30)),
                ($urandom_range(3) == 0) ? int'($urandom_range(f_len - 1)) : -1);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_zero_len();
    test_abort();
    test_counter_limit();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_det_ctrl.md
PATTERN_DET_CTRL -- requirements
Module: pattern_det_ctrl

Interface
REQ-001 Parameter PAT_W, default 4, pattern length in bits.
REQ-002 Parameter LEN_W, default 10, width of the frame bit-count.
REQ-003 Parameter CNT_W, default 8, width of the match counter.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port rst  input  1  asynchronous active-low reset.
REQ-007 Port start  input  1  frame start request; honoured only in IDLE.
REQ-008 Port abort  input  1  terminate the frame; sampled in RUN only.
REQ-009 Port pattern  input  PAT_W  target pattern; first-received bit at the MSB; captured on start.
REQ-010 Port ovl_mode  input  1  1 = overlapping detection, 0 = non-overlapping; captured on start.
REQ-011 Port frame_len  input  LEN_W  bits in the frame; captured on start.
REQ-012 Port bit_valid  input  1  serial bit is present.
REQ-013 Port bit_in  input  1  serial data bit.
REQ-014 Port bit_ready  output  1  controller accepts a bit this cycle.
REQ-015 Port busy  output  1  high in RUN and DONE.
REQ-016 Port match  output  1  single-cycle pulse per detected pattern.
REQ-017 Port done  output  1  single-cycle pulse at normal frame end.
REQ-018 Port match_cnt  output  CNT_W  matches in the current or last frame.

Function
REQ-019 The FSM SHALL have exactly three states, IDLE, RUN and DONE, held in a registered state variable.
REQ-020 In IDLE, start=1 SHALL capture pattern, ovl_mode and frame_len, clear history, fill and match_cnt, and move to RUN; if frame_len==0 it SHALL move to DONE instead.
REQ-021 bit_ready SHALL be 1 only in RUN; a bit is accepted when bit_valid and bit_ready are both 1.
REQ-022 On acceptance: history <= {history[PAT_W-2:0], bit_in}; fill increments, saturating at PAT_W; the received-bit count increments.
REQ-023 A hit occurs when the post-shift fill equals PAT_W and the post-shift history equals the captured pattern.
REQ-024 On a hit, match SHALL pulse in the cycle after acceptance and match_cnt SHALL increment in that same cycle.
REQ-025 In non-overlapping mode a hit SHALL reset fill to 0; in overlapping mode fill is unchanged.
REQ-026 Acceptance of bit number frame_len SHALL move the FSM to DONE; no further bits are accepted.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE; a hit on the last bit pulses match in the same cycle as done.
REQ-028 abort=1 in RUN SHALL return the FSM to IDLE next cycle with no done pulse and match_cnt retained; a bit accepted in the same cycle is discarded.
REQ-029 start SHALL be ignored outside IDLE; bit_valid SHALL be ignored outside RUN.
REQ-030 match_cnt SHALL hold its value in IDLE until the next start.

Reset
REQ-031 rst=0 SHALL force IDLE and clear history, fill, the bit count, match_cnt, match, done, busy and bit_ready, asynchronously, including mid-frame.

Configuration
REQ-032 With MATCH_CNT_SAT_EN defined, match_cnt SHALL saturate at 2^CNT_W-1.
REQ-033 Without MATCH_CNT_SAT_EN, match_cnt SHALL wrap modulo 2^CNT_W.

Structure
REQ-034 Package pattern_det_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default PAT_W, LEN_W and CNT_W constants.
REQ-035 The history shift register, fill counter and comparator SHALL form sub-module pat_matcher, which outputs hit; the FSM and counters stay in the top module.

Verification
REQ-036 pattern=1010, ovl=1, len=6, bits 101010 with bit_valid held high -> two match pulses, match_cnt=2, done in the cycle after the 6th accept.
REQ-037 The same stimulus with ovl=0 -> one match pulse, match_cnt=1.
REQ-038 pattern=0000, ovl=1, len=300, all zeros -> 297 hits; match_cnt=255 with MATCH_CNT_SAT_EN, 41 without.
REQ-039 len=0 start -> DONE next cycle, done pulse, bit_ready never high, match_cnt=0.
REQ-040 abort after 3 bits, then start with len=4 and bits 1010 -> no done on the abort, second frame match_cnt=1 with match and done coincident.
REQ-041 rst=0 asserted mid-RUN with bit_valid gaps -> all outputs 0 immediately, state IDLE; a start after release behaves as from power-up.
